// File: rtl/vai_serve_tx.sv
// rtl/vai_serve_tx.sv - VAI sub-AFU Tx multiplexer: per-AFU request FIFOs, round-robin merge,
// vmid stamping into mdata and per-VM address relocation.
package vai_ccip_pkg;
  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]  rsvd2;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                valid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  localparam logic [3:0] REQ_WRFENCE = 4'h4;
  localparam logic [3:0] REQ_INTR    = 4'h6;
endpackage

module vai_serve_tx
  import vai_ccip_pkg::*;
#(
  parameter int NUM_SUB_AFUS   = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALMFULL_THRESH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  t_if_ccip_Tx             afu_TxPort [NUM_SUB_AFUS],
  input  logic [63:0]             offset_array [NUM_SUB_AFUS],
  input  logic                    up_c0_almfull,
  input  logic                    up_c1_almfull,
  output t_if_ccip_Tx             up_TxPort,
  output logic [NUM_SUB_AFUS-1:0] afu_c0_almfull,
  output logic [NUM_SUB_AFUS-1:0] afu_c1_almfull,
  output logic [NUM_SUB_AFUS-1:0] err_overflow,
  output logic                    err_c2_collision
);
  localparam int LNUM = $clog2(NUM_SUB_AFUS);
  localparam int LDEP = $clog2(FIFO_DEPTH);
  localparam logic [LDEP:0] DEPTH_C  = (LDEP+1)'(FIFO_DEPTH);
  localparam logic [LDEP:0] THRESH_C = (LDEP+1)'(ALMFULL_THRESH);
  localparam logic [NUM_SUB_AFUS-1:0] ONE_N = NUM_SUB_AFUS'(1);

  typedef logic [LNUM-1:0] t_idx;
  typedef logic [LDEP-1:0] t_ptr;
  typedef logic [LDEP:0]   t_cnt;

  t_ccip_c0_ReqMemHdr c0_mem  [NUM_SUB_AFUS][FIFO_DEPTH];
  t_ccip_c1_ReqMemHdr c1_hmem [NUM_SUB_AFUS][FIFO_DEPTH];
  logic [511:0]       c1_dmem [NUM_SUB_AFUS][FIFO_DEPTH];
  t_ptr c0_wp [NUM_SUB_AFUS], c0_rp [NUM_SUB_AFUS], c1_wp [NUM_SUB_AFUS], c1_rp [NUM_SUB_AFUS];
  t_cnt c0_cnt [NUM_SUB_AFUS], c1_cnt [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] c0_req, c1_req, c0_push, c1_push, c0_pop, c1_pop, c2_vld;

  t_idx c0_ptr, c1_ptr, c0_win, c1_win, c2_win, c1_lock_afu;
  logic c0_gnt, c1_gnt, c1_lock, c1_is_mem, offset_hi_unused;
  logic [1:0] c1_beats;
  t_ccip_c0_ReqMemHdr c0_head, c0_xlat;
  t_ccip_c1_ReqMemHdr c1_head, c1_xlat;
  t_if_ccip_c0_Tx c0_s1;
  t_if_ccip_c1_Tx c1_s1;
  t_if_ccip_c2_Tx c2_s1;

  // First requester at or after ptr, wrapping; NUM_SUB_AFUS is a power of two.
  function automatic t_idx rr_pick(input logic [NUM_SUB_AFUS-1:0] req, input t_idx ptr);
    t_idx idx;
    rr_pick = ptr;
    for (int i = NUM_SUB_AFUS-1; i >= 0; i--) begin
      idx = ptr + t_idx'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    offset_hi_unused = 1'b0;
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      c0_req[n] = (c0_cnt[n] != '0);
      c1_req[n] = (c1_cnt[n] != '0);
      offset_hi_unused = offset_hi_unused ^ (^offset_array[n][63:42]);
    end
  end

  // A locked c1 arbiter only serves the owner of the in-flight multi-line write.
  always_comb begin
    c0_win = rr_pick(c0_req, c0_ptr);
    c0_gnt = (|c0_req) && !up_c0_almfull;
    if (c1_lock) begin
      c1_win = c1_lock_afu;
      c1_gnt = c1_req[c1_lock_afu] && !up_c1_almfull;
    end else begin
      c1_win = rr_pick(c1_req, c1_ptr);
      c1_gnt = (|c1_req) && !up_c1_almfull;
    end
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      c0_pop[n]  = c0_gnt && (c0_win == t_idx'(n));
      c1_pop[n]  = c1_gnt && (c1_win == t_idx'(n));
      c0_push[n] = afu_TxPort[n].c0.valid && ((c0_cnt[n] != DEPTH_C) || c0_pop[n]);
      c1_push[n] = afu_TxPort[n].c1.valid && ((c1_cnt[n] != DEPTH_C) || c1_pop[n]);
    end
  end

  always_comb begin
    c0_head = c0_mem[c0_win][c0_rp[c0_win]];
    c0_xlat = c0_head;
    c0_xlat.mdata[15 -: LNUM] = c0_win;
    c0_xlat.address = c0_head.address + offset_array[c0_win][41:0];
    c1_head = c1_hmem[c1_win][c1_rp[c1_win]];
    c1_is_mem = (c1_head.req_type != REQ_WRFENCE) && (c1_head.req_type != REQ_INTR);
    c1_xlat = c1_head;
    c1_xlat.mdata[15 -: LNUM] = c1_win;
    if (c1_is_mem) c1_xlat.address = c1_head.address + offset_array[c1_win][41:0];
  end

  always_comb begin
    c2_win = '0;
    for (int n = NUM_SUB_AFUS-1; n >= 0; n--) begin
      c2_vld[n] = afu_TxPort[n].c2.valid;
      if (afu_TxPort[n].c2.valid) c2_win = t_idx'(n);
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      if (c0_push[n]) c0_mem[n][c0_wp[n]] <= afu_TxPort[n].c0.hdr;
      if (c1_push[n]) begin
        c1_hmem[n][c1_wp[n]] <= afu_TxPort[n].c1.hdr;
        c1_dmem[n][c1_wp[n]] <= afu_TxPort[n].c1.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        c0_wp[n] <= '0; c0_rp[n] <= '0; c0_cnt[n] <= '0;
        c1_wp[n] <= '0; c1_rp[n] <= '0; c1_cnt[n] <= '0;
      end
      afu_c0_almfull   <= '0;
      afu_c1_almfull   <= '0;
      err_overflow     <= '0;
      err_c2_collision <= 1'b0;
      c0_ptr <= '0; c1_ptr <= '0;
      c1_lock <= 1'b0; c1_lock_afu <= '0; c1_beats <= '0;
      c0_s1 <= '0; c1_s1 <= '0; c2_s1 <= '0;
      up_TxPort <= '0;
    end else begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        if (c0_push[n]) c0_wp[n] <= c0_wp[n] + t_ptr'(1);
        if (c0_pop[n])  c0_rp[n] <= c0_rp[n] + t_ptr'(1);
        if (c1_push[n]) c1_wp[n] <= c1_wp[n] + t_ptr'(1);
        if (c1_pop[n])  c1_rp[n] <= c1_rp[n] + t_ptr'(1);
        c0_cnt[n] <= c0_cnt[n] + t_cnt'(c0_push[n]) - t_cnt'(c0_pop[n]);
        c1_cnt[n] <= c1_cnt[n] + t_cnt'(c1_push[n]) - t_cnt'(c1_pop[n]);
        afu_c0_almfull[n] <= (c0_cnt[n] >= THRESH_C);
        afu_c1_almfull[n] <= (c1_cnt[n] >= THRESH_C);
        if ((afu_TxPort[n].c0.valid && !c0_push[n]) || (afu_TxPort[n].c1.valid && !c1_push[n]))
          err_overflow[n] <= 1'b1;
      end

      if (c0_gnt) c0_ptr <= c0_win + t_idx'(1);
      if (c1_gnt) begin
        if (c1_lock) begin
          c1_beats <= c1_beats - 2'd1;
          if (c1_beats == 2'd1) c1_lock <= 1'b0;
        end else begin
          c1_ptr <= c1_win + t_idx'(1);
          if (c1_is_mem && c1_head.sop && (c1_head.cl_len != 2'd0)) begin
            c1_lock     <= 1'b1;
            c1_lock_afu <= c1_win;
            c1_beats    <= c1_head.cl_len;
          end
        end
      end

      c0_s1.valid <= c0_gnt;
      if (c0_gnt) c0_s1.hdr <= c0_xlat;
      c1_s1.valid <= c1_gnt;
      if (c1_gnt) begin
        c1_s1.hdr  <= c1_xlat;
        c1_s1.data <= c1_dmem[c1_win][c1_rp[c1_win]];
      end
      c2_s1.valid <= |c2_vld;
      if (|c2_vld) begin
        c2_s1.hdr  <= afu_TxPort[c2_win].c2.hdr;
        c2_s1.data <= afu_TxPort[c2_win].c2.data;
      end
      if ((c2_vld & (c2_vld - ONE_N)) != '0) err_c2_collision <= 1'b1;

      up_TxPort.c0 <= c0_s1;
      up_TxPort.c1 <= c1_s1;
      up_TxPort.c2 <= c2_s1;
    end
  end
endmodule

// File: doc/vai_serve_tx.md
# vai_serve_tx

Transmit-side multiplexer for the VAI sub-AFU fabric. It collects CCI-P Tx requests from NUM_SUB_AFUS sub-AFUs into one upstream Tx port. On the way it:
- stamps the issuing vmid into the top mdata bits;
- relocates memory addresses by the per-VM offset that the receive path latches from hypervisor control MMIO writes;
- forwards MMIO read responses on c2.

It sits between the sub-AFUs and the upstream CCI-P port and is the counterpart of the Rx demultiplexer. That demultiplexer strips the vmid from mdata and routes responses back.

## Interface
- NUM_SUB_AFUS, 8, number of sub-AFUs; power of two, ≥2; LNUM = $clog2(NUM_SUB_AFUS)
- FIFO_DEPTH, 16, entries per per-AFU per-channel request FIFO; power of two
- ALMFULL_THRESH, 8, occupancy at or above which the per-AFU almost-full is asserted
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- afu_TxPort  in  t_if_ccip_Tx [NUM_SUB_AFUS]  per-AFU c0/c1/c2 requests
- offset_array  in  64 [NUM_SUB_AFUS]  per-VM cache-line address offset
- up_c0_almfull  in  1  upstream c0TxAlmFull
- up_c1_almfull  in  1  upstream c1TxAlmFull
- up_TxPort  out  t_if_ccip_Tx  merged upstream Tx
- afu_c0_almfull  out  [NUM_SUB_AFUS]  per-AFU c0 backpressure
- afu_c1_almfull  out  [NUM_SUB_AFUS]  per-AFU c1 backpressure
- err_overflow  out  [NUM_SUB_AFUS]  sticky; a push hit a full FIFO
- err_c2_collision  out  1  sticky; two or more c2 valids in the same cycle

## Operation
- **Request FIFOs.** Each AFU n has a c0 FIFO and a c1 FIFO.
  - A push happens on afu_TxPort[n].cX.valid.
  - A push to a full FIFO is dropped and sets err_overflow[n].
  - afu_cX_almfull[n] = (count ≥ ALMFULL_THRESH), registered.
- **Arbitration.** c0 and c1 use independent round-robin arbiters over the non-empty FIFOs.
  - Priority starts at pointer p. After a grant to index w, p ← w+1 mod NUM_SUB_AFUS.
  - Reset value of p is 0.
  - No grant occurs while the matching up_cX_almfull is 1. Requests already in the output pipeline still issue; at most 2 per channel.
- **c1 multi-line lock.** A grant on a write with sop=1 and cl_len=L locks the c1 arbiter to that AFU for L+1 beats.
  - L encodes 1, 2 or 4 lines as 0, 1 or 3.
  - While locked, p does not advance. The lock releases after the last beat is popped.
  - If upstream almfull asserts mid-packet, the lock holds and issue stalls. Beats of different AFUs never interleave.
- **Header translation** applies to the granted entry of AFU w.
  - mdata[15 -: LNUM] ← w. Any AFU-supplied value in those bits is overwritten. Lower mdata bits pass through.
  - c0 reads and c1 write beats: address ← (address + offset_array[w][41:0]) mod 2^42.
  - c1 fence and interrupt requests: address passes through unchanged.
  - All other header fields and data pass through unchanged.
  - offset_array is sampled at pop time.
- **c2 (MMIO read response).** No FIFO and no arbitration.
  - The lowest-index valid AFU wins; its hdr.tid and data are registered to up_TxPort.c2.
  - If more than one AFU is valid in the same cycle, the losers are dropped and err_c2_collision is set.
- **Reset values.**
  - All up_TxPort valids are 0 and all headers/data are 0.
  - All FIFOs are empty, all locks are cleared, and all almfull and err outputs are 0.
  - A reset mid-packet discards partial packets. The downstream consumer is reset in the same cycle.

## Timing
- A request sampled at edge E0 is in the FIFO after E0. If it is granted in the following cycle, it appears on up_TxPort after E2: 2-cycle latency when idle, one grant/pop stage plus a registered output.
- Sustained throughput is 1 request per cycle per channel.
- Simultaneous push and pop on the same FIFO leaves count unchanged.
- A full FIFO plus a pop and push in the same cycle is accepted with no overflow.
- almfull rises 1 cycle after count reaches the threshold.
- c2 latency is 1 cycle: afu valid at E0 gives up valid after E1.
- The upstream almfull is sampled in the grant cycle. Deasserting it allows a grant in the same cycle.

## Test plan
- **vmid stamp and relocation.** Stimulus: AFU 3 issues a c0 read with address 0x100 and mdata 0x0ABC; offset_array[3] = 0x4000. Required: after E2, up c0 has address 0x4100 and mdata 0x6ABC (NUM_SUB_AFUS=8).
- **Round-robin.** Stimulus: AFUs 0, 2 and 5 each push 2 c0 reads in one cycle. Required: issue order 0, 2, 5, 0, 2, 5 on consecutive cycles.
- **Multi-line lock.** Stimulus: AFU 1 sends a 4-line c1 write (sop, cl_len=3). AFU 4 sends a single write during beat 2. Required: 4 contiguous AFU 1 beats, each with address + offset, then AFU 4.
- **Backpressure.**
  - Hold up_c0_almfull=1 while AFU 0 pushes 9 reads. Required: no new grants; afu_c0_almfull[0]=1 after count 8; err_overflow stays 0.
  - Then push 8 more reads. Required: the 17th push sets err_overflow[0].
- **c2 path.** Stimulus: AFU 6 sends c2 with tid 0x1F and data 0xDEAD. Required: up c2 after E1 with the same tid and data. A simultaneous AFU 2 and AFU 6 c2 forwards AFU 2 and sets err_c2_collision.
- **Reset mid-packet.** Stimulus: assert reset after beat 2 of a 4-line write. Required: all outputs 0 after the reset edge, FIFOs empty, lock released; the next request issues normally.
